// File: rtl/instruction_fetch_ctrl.sv
// PC sequencer and one-deep fetch register in front of a combinational ROM.
// Ports: Clock/Reset, run/stall/branch controls, ROM address/data,
// registered instruction+PC+valid to decode, halt flag, issue counter.
module instruction_fetch_ctrl #(
  parameter logic [15:0] LAST_ADDR   = 16'd14,
  parameter logic [7:0]  HALT_OPCODE = 8'hFF,
  parameter logic [15:0] RESET_PC    = 16'd0
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        iEnable,
  input  logic        iStall,
  input  logic        iBranchTaken,
  input  logic [15:0] iBranchTarget,
  output logic [15:0] oRomAddress,
  input  logic [27:0] iRomInstruction,
  output logic [27:0] oInstruction,
  output logic        oInstrValid,
  output logic [15:0] oPC,
  output logic        oHalted,
  output logic [15:0] oIssueCount
);

  typedef enum logic [1:0] {
    PAUSED,
    RUN,
    HALTED
  } state_t;

  state_t      state, state_nx;
  logic [15:0] fetch_pc, fetch_pc_nx;
  logic [27:0] instr, instr_nx;
  logic [15:0] pc, pc_nx;
  logic        valid, valid_nx;
  logic [15:0] count, count_nx;

  logic redirect;
  logic is_halt;
  logic [15:0] pc_inc;

  // A branch only counts when it refers to a real issued word.
  assign redirect = iBranchTaken && valid;
  assign is_halt  = iRomInstruction[27:20] == HALT_OPCODE;
  assign pc_inc   = (fetch_pc == LAST_ADDR) ? 16'd0 : fetch_pc + 16'd1;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state    <= PAUSED;
      fetch_pc <= RESET_PC;
      instr    <= '0;
      pc       <= '0;
      valid    <= 1'b0;
      count    <= '0;
    end else begin
      state    <= state_nx;
      fetch_pc <= fetch_pc_nx;
      instr    <= instr_nx;
      pc       <= pc_nx;
      valid    <= valid_nx;
      count    <= count_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    fetch_pc_nx = fetch_pc;
    instr_nx    = instr;
    pc_nx       = pc;
    valid_nx    = valid;
    count_nx    = count;
    unique case (state)
      PAUSED: begin
        valid_nx = 1'b0;
        if (iEnable) state_nx = RUN;
      end
      RUN: begin
        if (!iEnable) begin
          state_nx = PAUSED;
          valid_nx = 1'b0;
          if (redirect) fetch_pc_nx = iBranchTarget;
        end else if (redirect) begin
          // Wrong-path word at fetch_pc is dropped: one bubble.
          fetch_pc_nx = iBranchTarget;
          valid_nx    = 1'b0;
        end else if (!iStall) begin
          instr_nx = iRomInstruction;
          pc_nx    = fetch_pc;
          valid_nx = 1'b1;
          if (count != 16'hFFFF) count_nx = count + 16'd1;
          if (is_halt) state_nx = HALTED;
          else fetch_pc_nx = pc_inc;
        end
      end
      HALTED: begin
        // Halt word stays visible until accepted or branched away.
        if (redirect || !iStall) valid_nx = 1'b0;
      end
      default: state_nx = PAUSED;
    endcase
  end

  assign oRomAddress  = fetch_pc;
  assign oInstruction = instr;
  assign oInstrValid  = valid;
  assign oPC          = pc;
  assign oHalted      = state == HALTED;
  assign oIssueCount  = count;

endmodule
